uart_rx: RTL and testbench

//  UART receiver feeding the Processor's rx pin; partner of the tx path (8N1, LSB first, line idles high).

---
 rtl/uart_rx_pkg.sv | 17 +
 rtl/uart_rx_if.sv | 29 ++
 rtl/uart_rx_sync_2ff.sv | 28 ++
 rtl/uart_rx.sv | 169 ++++++++++++++++
 tb/tb_uart_rx.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg
//   Shared definitions for the UART receive path: default frame timing and
//   the receiver FSM state encoding (3-bit codes, shared with the tx block).
package uart_rx_pkg;

  localparam int UART_CLKS_PER_BIT = 434;  // 50 MHz / 115200
  localparam int UART_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_RECOVER = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if
//   Byte handshake between the UART receiver and its consumer.
//   rx_data   received byte, stable while rx_valid=1
//   rx_valid  byte available, held until accepted
//   rx_ready  consumer accepts when rx_valid & rx_ready
//   master = receiver side, slave = consumer side.
interface uart_rx_if
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS
);

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// uart_rx_sync_2ff
//   Two-flop synchroniser for a single asynchronous input.
//   clk    destination clock
//   reset  asynchronous, active-low; both flops load RESET_VAL
//   d      asynchronous input
//   q      synchronised output, two clk cycles behind d
module uart_rx_sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx
//   8N1-style UART receiver (LSB first, line idles high). Validates the
//   start bit at mid-bit, samples data/stop bits at bit centres and hands
//   each byte to the consumer over a valid/ready handshake.
//   clk        system clock
//   reset      asynchronous, active-low; clears all state
//   rx         serial line, asynchronous to clk
//   bus        uart_rx_if.master: rx_data / rx_valid / rx_ready
//   frame_err  1-cycle pulse: stop bit sampled 0
//   overrun    1-cycle pulse: byte completed while previous unaccepted
//   busy       1 when the FSM is not idle
//
//   state      | meaning
//   -----------+--------------------------------------------------------
//   ST_IDLE    | line idle, waiting for rx_s low
//   ST_START   | timing to start-bit centre, re-check low (glitch reject)
//   ST_DATA    | sampling DATA_BITS data bits at bit centres
//   ST_STOP    | sampling stop bit at its centre
//   ST_RECOVER | stop bit was low, wait for line high before re-arming
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  uart_rx_if.master  bus,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS) + 1;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic rx_s;

  uart_rx_sync_2ff #(.RESET_VAL(1'b1)) u_sync_rx (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  uart_state_e          state, state_nxt;
  logic [CNT_W-1:0]     clk_cnt, cnt_nxt;
  logic [IDX_W-1:0]     bit_idx, idx_nxt;
  logic [DATA_BITS-1:0] shift_reg, shift_nxt;
  logic                 deliver, deliver_nxt;
  logic                 ferr_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      deliver   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      clk_cnt   <= cnt_nxt;
      bit_idx   <= idx_nxt;
      shift_reg <= shift_nxt;
      deliver   <= deliver_nxt;
      frame_err <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = clk_cnt;
    idx_nxt     = bit_idx;
    shift_nxt   = shift_reg;
    deliver_nxt = 1'b0;
    ferr_nxt    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rx_s) begin
          state_nxt = ST_START;
          cnt_nxt   = '0;
        end
      end
      ST_START: begin
        if (clk_cnt == CNT_HALF) begin
          cnt_nxt = '0;
          if (!rx_s) begin
            state_nxt = ST_DATA;
            idx_nxt   = '0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (clk_cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          // right shift: first (LSB) bit ends up in bit 0 after the last shift
          shift_nxt = {rx_s, shift_reg[DATA_BITS-1:1]};
          idx_nxt   = bit_idx + IDX_W'(1);
          if (bit_idx == IDX_LAST) begin
            state_nxt = ST_STOP;
          end
        end else begin
          cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (clk_cnt == CNT_LAST) begin
          cnt_nxt = '0;
          // leave at stop centre so a back-to-back start edge is not missed
          if (rx_s) begin
            deliver_nxt = 1'b1;
            state_nxt   = ST_IDLE;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = ST_RECOVER;
          end
        end else begin
          cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end
      ST_RECOVER: begin
        // a held-low break must not look like a new start bit
        if (rx_s) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;

  // Delivery wins over accept; a same-cycle accept frees the slot for the new byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (deliver) begin
        if (!valid_q || bus.rx_ready) begin
          data_q  <= shift_reg;
          valid_q <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid_q && bus.rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.rx_data  = data_q;
  assign bus.rx_valid = valid_q;
  assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int CPB = 16;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic rx    = 1'b1;
  logic frame_err, overrun, busy;

  uart_rx_if #(.DATA_BITS(8)) bus ();

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .bus       (bus),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #10 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // event monitors, sampled on the falling edge
  int         ferr_cyc   = 0;
  int         ovr_cyc    = 0;
  int         busy_cyc   = 0;
  int         vrise      = 0;
  int         vrise_at   = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] acc_log[$];

  always @(negedge clk) begin
    if (frame_err) ferr_cyc++;
    if (overrun)   ovr_cyc++;
    if (busy)      busy_cyc++;
    if (bus.rx_valid && !prev_valid) begin
      vrise++;
      vrise_at = cyc;
    end
    prev_valid = bus.rx_valid;
    if (bus.rx_valid && bus.rx_ready) acc_log.push_back(bus.rx_data);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // call on a falling edge; one bit = CPB clocks
  task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_len);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (stop_len) @(negedge clk);
  endtask

  int t0, a0, f0, o0, v0, b0;
  logic [7:0] g0, g1;

  initial begin
    bus.rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(bus.rx_valid), 32'd0);
    chk("rst_data",  32'(bus.rx_data),  32'h00);
    chk("rst_busy",  32'(busy),         32'd0);
    chk("rst_ferr",  32'(frame_err),    32'd0);
    chk("rst_ovr",   32'(overrun),      32'd0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // 1: single byte, not accepted
    v0 = vrise;
    t0 = cyc;
    send_frame(8'hA5, 1'b1, CPB);
    chk("t1_latency", 32'(vrise_at - t0), 32'd156);
    chk("t1_rises",   32'(vrise - v0),    32'd1);
    repeat (20) @(negedge clk);
    chk("t1_valid_held", 32'(bus.rx_valid), 32'd1);
    chk("t1_data",       32'(bus.rx_data),  32'hA5);

    // 2: accept, then back-to-back frames with ready held high
    bus.rx_ready = 1'b1;
    @(negedge clk);
    chk("t2_accept_clr", 32'(bus.rx_valid), 32'd0);
    chk("t2_data_kept",  32'(bus.rx_data),  32'hA5);
    a0 = acc_log.size(); f0 = ferr_cyc; o0 = ovr_cyc;
    send_frame(8'h00, 1'b1, CPB);
    send_frame(8'hFF, 1'b1, CPB);
    repeat (4) @(negedge clk);
    g0 = (acc_log.size() > a0)     ? acc_log[a0]     : 8'hxx;
    g1 = (acc_log.size() > a0 + 1) ? acc_log[a0 + 1] : 8'hxx;
    chk("t2_n_acc",  32'(acc_log.size() - a0), 32'd2);
    chk("t2_byte0",  32'(g0),                  32'h00);
    chk("t2_byte1",  32'(g1),                  32'hFF);
    chk("t2_ferr",   32'(ferr_cyc - f0),       32'd0);
    chk("t2_ovr",    32'(ovr_cyc - o0),        32'd0);
    bus.rx_ready = 1'b0;
    repeat (4) @(negedge clk);

    // 3: 5-clock low glitch -> START for 8 clocks, back to idle
    b0 = busy_cyc; v0 = vrise;
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("t3_busy_cycles", 32'(busy_cyc - b0), 32'd8);
    chk("t3_no_valid",    32'(vrise - v0),    32'd0);
    chk("t3_idle",        32'(busy),          32'd0);

    // 4: stop bit low, line held low 40 clocks
    f0 = ferr_cyc; v0 = vrise;
    send_frame(8'h3C, 1'b0, 40);
    chk("t4_busy_recover", 32'(busy),           32'd1);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    chk("t4_ferr_pulse",   32'(ferr_cyc - f0),  32'd1);
    chk("t4_no_valid",     32'(vrise - v0),     32'd0);
    chk("t4_valid_low",    32'(bus.rx_valid),   32'd0);
    chk("t4_idle",         32'(busy),           32'd0);

    // 5: overrun, then a delivery that coincides with an accept
    o0 = ovr_cyc;
    send_frame(8'h11, 1'b1, CPB);
    repeat (2) @(negedge clk);
    chk("t5_first", 32'(bus.rx_data), 32'h11);
    send_frame(8'h22, 1'b1, CPB);
    repeat (2) @(negedge clk);
    chk("t5_ovr_pulse",  32'(ovr_cyc - o0),   32'd1);
    chk("t5_data_kept",  32'(bus.rx_data),    32'h11);
    chk("t5_valid_kept", 32'(bus.rx_valid),   32'd1);
    o0 = ovr_cyc;
    fork
      send_frame(8'h22, 1'b1, CPB);
      begin
        repeat (155) @(negedge clk);
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
      end
    join
    repeat (2) @(negedge clk);
    chk("t5_no_ovr",   32'(ovr_cyc - o0),  32'd0);
    chk("t5_new_data", 32'(bus.rx_data),   32'h22);
    chk("t5_valid",    32'(bus.rx_valid),  32'd1);

    // 6: reset in the middle of bit 4, then a clean frame
    fork
      send_frame(8'hC3, 1'b1, CPB);
      begin
        repeat (CPB * 5 + 8) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(bus.rx_valid), 32'd0);
        chk("t6_rst_data",  32'(bus.rx_data),  32'h00);
        chk("t6_rst_busy",  32'(busy),         32'd0);
      end
    join
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    f0 = ferr_cyc; o0 = ovr_cyc; v0 = vrise;
    send_frame(8'h5A, 1'b1, CPB);
    repeat (4) @(negedge clk);
    chk("t6_data",  32'(bus.rx_data),   32'h5A);
    chk("t6_valid", 32'(bus.rx_valid),  32'd1);
    chk("t6_rises", 32'(vrise - v0),    32'd1);
    chk("t6_ferr",  32'(ferr_cyc - f0), 32'd0);
    chk("t6_ovr",   32'(ovr_cyc - o0),  32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
